noc_packet_rr_mux: RTL and testbench
====================================

// Module: noc_packet_rr_mux
// PURPOSE
//  Packet-atomic round-robin multiplexer merging INPUTS flit streams (e.g. outputs of
//  per-source noc_buffer instances) onto one NoC link. Arbitration happens only at
//  packet boundaries: once a head flit is granted, the input holds the link until its
//  last flit is accepted. Registered output stage; stalled-packet detector for fault reporting.
// PARAMETERS
//  FLIT_WIDTH   32  flit payload width
//  INPUTS       4   number of input streams; must be >= 2
//  STALL_LIMIT  64  idle cycles of a locked input (mid-packet) before err_stall is raised; >= 1
// PORTS
//  clk         in   1                    clock
//  rst         in   1                    synchronous reset, active high
//  in_flit     in   INPUTS*FLIT_WIDTH    input i occupies bits [i*FLIT_WIDTH +: FLIT_WIDTH]
//  in_last     in   INPUTS               last flit of packet, per input
//  in_valid    in   INPUTS               flit valid, per input
//  in_ready    out  INPUTS               flit accepted when in_valid[i] & in_ready[i]
//  out_flit    out  FLIT_WIDTH           registered output flit
//  out_last    out  1                    registered last marker
//  out_src     out  $clog2(INPUTS)       index of the input that supplied out_flit
//  out_valid   out  1                    output flit valid
//  out_ready   in   1                    downstream ready
//  err_stall   out  1                    sticky: locked input starved for STALL_LIMIT cycles
// BEHAVIOUR
//  Interface: one clock, clk; reset rst is synchronous, active high.
//  Reset values: out_valid=0, out_flit=0, out_last=0, out_src=0, err_stall=0, state=IDLE,
//   rr_ptr=0, stall_cnt=0. A reset mid-packet discards the partial packet; no flit is replayed.
//  can_accept = ~out_valid | out_ready. xfer = a flit is taken from the selected input this cycle.
//  State IDLE: cand = first i with in_valid[i], scanning rr_ptr, rr_ptr+1, ... mod INPUTS.
//   in_ready[cand] = can_accept; all other in_ready = 0. No valid input -> all in_ready = 0.
//   On xfer with in_last=0: go to LOCKED, sel <= cand.
//   On xfer with in_last=1 (1-flit packet): stay IDLE, rr_ptr <= (cand+1) mod INPUTS.
//  State LOCKED: in_ready[sel] = can_accept; all others 0; other inputs are ignored.
//   On xfer with in_last=1: go to IDLE, rr_ptr <= (sel+1) mod INPUTS.
//  in_ready depends combinationally on in_valid (IDLE only) and on out_ready.
//  Output stage: on xfer, load out_flit/out_last/out_src and set out_valid=1. Without xfer,
//   clear out_valid when out_ready=1; hold all outputs when out_valid & ~out_ready.
//  Latency: input handshake to out_valid is exactly 1 cycle. Throughput: 1 flit/cycle with
//   out_ready held high, including back-to-back packets from different inputs (no bubble at
//   packet switch).
//  Stall detector: stall_cnt width $clog2(STALL_LIMIT+1). In LOCKED with in_valid[sel]=0:
//   stall_cnt += 1, saturating at STALL_LIMIT. Cleared on any xfer and in IDLE.
//   Downstream back-pressure (in_valid[sel]=1, can_accept=0) does not count.
//   When stall_cnt reaches STALL_LIMIT, err_stall <= 1; it stays 1 until rst. The lock is
//   kept; the packet is never truncated.
//  Fairness: with all inputs continuously valid, packets are granted strictly 0,1,...,INPUTS-1,0,...
// TESTING
//  1 rst; in_valid=4'b1111, 1-flit packets, out_ready=1 -> out_src sequence 0,1,2,3,0; 1 flit/cycle.
//  2 input 2 sends a 3-flit packet A0..A2 with input 0 valid meanwhile -> out = A0,A1,A2 (src 2),
//    then input 0; in_ready[0]=0 throughout A.
//  3 out_ready=0 for 5 cycles mid-packet -> out_flit/out_last/out_src hold; in_ready all 0;
//    no flit lost or duplicated; err_stall stays 0.
//  4 STALL_LIMIT=4; input 1 locked after head flit, drops in_valid -> err_stall=1 on the 4th idle
//    cycle; later tail accepted, state IDLE; err_stall remains 1 until rst.
//  5 rst asserted while LOCKED on input 3 -> next cycle out_valid=0, IDLE, rr_ptr=0; a new packet
//    on input 0 is granted immediately.
//  6 random valid/ready/packet lengths 1..8 on all inputs -> per-source flit order preserved,
//    packets never interleaved, all flits delivered (scoreboard).

Source files
------------

// File: rtl/noc_packet_rr_mux.sv
// Packet-atomic round-robin multiplexer: merges INPUTS flit streams onto one link.
// Arbitration only at packet boundaries; registered output stage; sticky stall detector.
module noc_packet_rr_mux #(
  parameter int FLIT_WIDTH  = 32,
  parameter int INPUTS      = 4,
  parameter int STALL_LIMIT = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INPUTS*FLIT_WIDTH-1:0] in_flit,
  input  logic [INPUTS-1:0]            in_last,
  input  logic [INPUTS-1:0]            in_valid,
  output logic [INPUTS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]        out_flit,
  output logic                         out_last,
  output logic [$clog2(INPUTS)-1:0]    out_src,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         err_stall
);

  localparam int SRC_W = $clog2(INPUTS);
  localparam int CNT_W = $clog2(STALL_LIMIT + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state_q, state_d;
  logic [SRC_W-1:0]        sel_q, sel_d;
  logic [SRC_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
  logic                    err_stall_q, err_stall_d;
  logic [FLIT_WIDTH-1:0]   out_flit_q, out_flit_d;
  logic                    out_last_q, out_last_d;
  logic [SRC_W-1:0]        out_src_q, out_src_d;
  logic                    out_valid_q, out_valid_d;

  logic [SRC_W-1:0]        cand;
  logic                    cand_vld;
  logic [SRC_W:0]          scan;
  logic [SRC_W-1:0]        grant;
  logic                    grant_vld;
  logic                    can_accept;
  logic                    xfer;
  logic [FLIT_WIDTH-1:0]   sel_flit;
  logic                    sel_last;

  // Wrap-around increment of an input index.
  function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] idx);
    if (idx == SRC_W'(INPUTS - 1)) return '0;
    return idx + SRC_W'(1);
  endfunction

  // Round-robin candidate: first valid input starting at rr_ptr. Scanning from the
  // farthest offset down lets the nearest valid input overwrite earlier hits.
  always_comb begin
    cand     = '0;
    cand_vld = 1'b0;
    scan     = '0;
    for (int k = INPUTS - 1; k >= 0; k--) begin
      scan = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
      if (scan >= (SRC_W+1)'(INPUTS)) scan = scan - (SRC_W+1)'(INPUTS);
      if (in_valid[scan[SRC_W-1:0]]) begin
        cand     = scan[SRC_W-1:0];
        cand_vld = 1'b1;
      end
    end
  end

  // Grant selection, ready generation and transfer qualification.
  always_comb begin
    can_accept = ~out_valid_q | out_ready;
    grant      = (state_q == LOCKED) ? sel_q : cand;
    grant_vld  = (state_q == LOCKED) ? 1'b1 : cand_vld;
    in_ready   = '0;
    if (grant_vld) in_ready[grant] = can_accept;
    xfer     = grant_vld & can_accept & in_valid[grant];
    sel_flit = '0;
    sel_last = 1'b0;
    for (int i = 0; i < INPUTS; i++) begin
      if (grant == SRC_W'(i)) begin
        sel_flit = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
        sel_last = in_last[i];
      end
    end
  end

  // Packet lock FSM: lock on a multi-flit head, release and advance rr_ptr on tail.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (sel_last) begin
            rr_ptr_d = next_idx(cand);
          end else begin
            state_d = LOCKED;
            sel_d   = cand;
          end
        end
      end
      LOCKED: begin
        if (xfer && sel_last) begin
          state_d  = IDLE;
          rr_ptr_d = next_idx(sel_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: load on transfer, drain when accepted, hold under back-pressure.
  always_comb begin
    out_flit_d  = out_flit_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    if (xfer) begin
      out_flit_d  = sel_flit;
      out_last_d  = sel_last;
      out_src_d   = grant;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Stall detector: counts only cycles where the locked input itself has no flit.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == IDLE || xfer) begin
      stall_cnt_d = '0;
    end else if (!in_valid[sel_q] && stall_cnt_q != CNT_W'(STALL_LIMIT)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    err_stall_d = err_stall_q | (stall_cnt_d == CNT_W'(STALL_LIMIT));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      stall_cnt_q <= '0;
      err_stall_q <= 1'b0;
      out_flit_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_ptr_q    <= rr_ptr_d;
      stall_cnt_q <= stall_cnt_d;
      err_stall_q <= err_stall_d;
      out_flit_q  <= out_flit_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_flit  = out_flit_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;
  assign err_stall = err_stall_q;

endmodule

// File: tb/tb_noc_packet_rr_mux.sv
// Testbench for noc_packet_rr_mux: vector table, directed corner sequences, random scoreboard.
module tb_noc_packet_rr_mux;

  localparam int FW = 32;
  localparam int NI = 4;
  localparam int SL = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NI*FW-1:0]  in_flit;
  logic [NI-1:0]     in_last;
  logic [NI-1:0]     in_valid;
  logic [NI-1:0]     in_ready;
  logic [FW-1:0]     out_flit;
  logic              out_last;
  logic [1:0]        out_src;
  logic              out_valid;
  logic              out_ready;
  logic              err_stall;

  int total = 0;
  int bad   = 0;

  noc_packet_rr_mux #(.FLIT_WIDTH(FW), .INPUTS(NI), .STALL_LIMIT(SL)) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .out_flit(out_flit), .out_last(out_last), .out_src(out_src),
    .out_valid(out_valid), .out_ready(out_ready), .err_stall(err_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic       rdy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_src;
    logic       exp_last;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] flit_of(input int i, input int r);
    return {8'(i), 8'(r), 16'h5A5A};
  endfunction

  task automatic put(input int i, input logic [FW-1:0] f);
    in_flit[i*FW +: FW] = f;
  endtask

  task automatic drive_row(input logic [3:0] v, input logic [3:0] l, input int r);
    in_valid = v;
    in_last  = l;
    for (int i = 0; i < NI; i++) put(i, flit_of(i, r));
  endtask

  // random-test state
  int unsigned rem [NI];
  int unsigned fidx [NI];
  int unsigned pkt [NI];
  bit          active [NI];
  bit          acc [NI];
  logic [FW:0] expq [NI][$];
  bit          out_in_pkt;
  logic [1:0]  out_lock_src;
  logic [FW:0] e;
  int          left;

  initial begin
    rst       = 1'b1;
    in_flit   = '0;
    in_last   = '0;
    in_valid  = '0;
    out_ready = 1'b1;

    // vector table: round robin over 1-flit packets, then packet lock on input 2
    tbl[0] = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    tbl[1] = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    tbl[2] = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
    tbl[3] = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
    tbl[4] = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    tbl[5] = '{4'b0101, 4'b0001, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[6] = '{4'b0101, 4'b0001, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[7] = '{4'b0101, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
    tbl[8] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    tbl[9] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};

    cyc();
    cyc();
    rst = 1'b0;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_flit", out_flit, 32'h0);
    chk("reset_out_last", out_last, 1'b0);
    chk("reset_out_src", out_src, 2'd0);
    chk("reset_err_stall", err_stall, 1'b0);
    chk("reset_in_ready", in_ready, 4'b0000);

    for (int r = 0; r < 10; r++) begin
      out_ready = tbl[r].rdy;
      drive_row(tbl[r].v, tbl[r].l, r);
      #1;
      chk($sformatf("tbl%0d_in_ready", r), in_ready, tbl[r].exp_rdy);
      cyc();
      chk($sformatf("tbl%0d_out_valid", r), out_valid, tbl[r].exp_ov);
      if (tbl[r].exp_ov) begin
        chk($sformatf("tbl%0d_out_src", r), out_src, tbl[r].exp_src);
        chk($sformatf("tbl%0d_out_last", r), out_last, tbl[r].exp_last);
        chk($sformatf("tbl%0d_out_flit", r), out_flit, flit_of(int'(tbl[r].exp_src), r));
      end
    end

    // back-pressure mid-packet: input 1 sends B0..B3, input 3 waits with a 1-flit packet
    in_valid = 4'b0010; in_last = 4'b0000; put(1, 32'hB000_0000);
    #1 chk("bp_head_ready", in_ready, 4'b0010);
    cyc();
    chk("bp_head_out", out_flit, 32'hB000_0000);
    in_valid = 4'b1010; in_last = 4'b1000; put(1, 32'hB000_0001); put(3, 32'hC000_0003);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("bp_stall%0d_in_ready", k), in_ready, 4'b0000);
      cyc();
      chk($sformatf("bp_stall%0d_hold", k), {out_valid, out_last, out_src, out_flit},
          {1'b1, 1'b0, 2'd1, 32'hB000_0000});
    end
    out_ready = 1'b1;
    #1 chk("bp_resume_ready", in_ready, 4'b0010);
    cyc();
    chk("bp_b1", {out_valid, out_last, out_src, out_flit}, {1'b1, 1'b0, 2'd1, 32'hB000_0001});
    put(1, 32'hB000_0002);
    cyc();
    chk("bp_b2", {out_valid, out_last, out_src, out_flit}, {1'b1, 1'b0, 2'd1, 32'hB000_0002});
    put(1, 32'hB000_0003); in_last = 4'b1010;
    cyc();
    chk("bp_b3", {out_valid, out_last, out_src, out_flit}, {1'b1, 1'b1, 2'd1, 32'hB000_0003});
    in_valid = 4'b1000;
    #1 chk("bp_next_ready", in_ready, 4'b1000);
    cyc();
    chk("bp_c", {out_valid, out_last, out_src, out_flit}, {1'b1, 1'b1, 2'd3, 32'hC000_0003});
    in_valid = 4'b0000;
    cyc();
    chk("bp_drain_valid", out_valid, 1'b0);
    chk("bp_err_stall", err_stall, 1'b0);

    // stall detector: input 1 locked, starved for STALL_LIMIT cycles
    in_valid = 4'b0010; in_last = 4'b0000; put(1, 32'hD000_0000);
    #1 chk("stall_head_ready", in_ready, 4'b0010);
    cyc();
    chk("stall_head_out", {out_valid, out_src, out_flit}, {1'b1, 2'd1, 32'hD000_0000});
    in_valid = 4'b0001; in_last = 4'b0001;
    for (int k = 1; k <= SL; k++) begin
      #1 chk($sformatf("stall_idle%0d_ready", k), in_ready, 4'b0010);
      cyc();
      chk($sformatf("stall_idle%0d_err", k), err_stall, (k == SL) ? 1'b1 : 1'b0);
    end
    cyc();
    chk("stall_sat_err", err_stall, 1'b1);
    in_valid = 4'b0011; in_last = 4'b0011; put(1, 32'hD000_0001); put(0, 32'hE000_0000);
    #1 chk("stall_tail_ready", in_ready, 4'b0010);
    cyc();
    chk("stall_tail_out", {out_valid, out_last, out_src, out_flit}, {1'b1, 1'b1, 2'd1, 32'hD000_0001});
    in_valid = 4'b0001;
    #1 chk("stall_idle_after_ready", in_ready, 4'b0001);
    cyc();
    chk("stall_next_out", {out_valid, out_src, out_flit}, {1'b1, 2'd0, 32'hE000_0000});
    chk("stall_err_sticky", err_stall, 1'b1);
    in_valid = 4'b0000;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("stall_err_cleared", err_stall, 1'b0);
    chk("stall_rst_valid", out_valid, 1'b0);

    // reset while locked on input 3
    in_valid = 4'b1000; in_last = 4'b0000; put(3, 32'hF000_0003);
    #1 chk("rstlock_head_ready", in_ready, 4'b1000);
    cyc();
    chk("rstlock_head_src", out_src, 2'd3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rstlock_state", {out_valid, out_src, out_flit}, {1'b0, 2'd0, 32'h0});
    in_valid = 4'b1001; in_last = 4'b0001; put(0, 32'h1234_0000);
    #1 chk("rstlock_new_ready", in_ready, 4'b0001);
    cyc();
    chk("rstlock_new_out", {out_valid, out_last, out_src, out_flit}, {1'b1, 1'b1, 2'd0, 32'h1234_0000});

    // random traffic with scoreboard
    in_valid = '0; in_last = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      rem[i] = 0; fidx[i] = 0; pkt[i] = 0; active[i] = 0; acc[i] = 0;
    end
    out_in_pkt = 1'b0;
    out_lock_src = '0;
    left = 1;
    for (int n = 0; n < 4000 && left != 0; n++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        acc[i] = in_valid[i] & in_ready[i];
        if (acc[i]) expq[i].push_back({in_last[i], in_flit[i*FW +: FW]});
      end
      if (out_valid && out_ready) begin
        if (expq[out_src].size() == 0) begin
          total++; bad++;
          $display("FAIL rand_unexpected: got flit %0h from src %0d, expected none", out_flit, out_src);
        end else begin
          e = expq[out_src].pop_front();
          chk("rand_flit", {out_last, out_flit}, e);
        end
        if (out_in_pkt) chk("rand_atomic_src", out_src, out_lock_src);
        out_in_pkt   = !out_last;
        out_lock_src = out_src;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (acc[i]) begin
          in_valid[i] = 1'b0;
          rem[i]--;
          fidx[i]++;
          if (rem[i] == 0) active[i] = 0;
        end
        if (!active[i] && n < 2000 && ($urandom % 3) == 0) begin
          active[i] = 1;
          rem[i]    = $urandom_range(1, 8);
          fidx[i]   = 0;
          pkt[i]++;
        end
        if (active[i] && !in_valid[i] && ($urandom % 4) != 0) begin
          in_valid[i] = 1'b1;
          in_last[i]  = (rem[i] == 1);
          put(i, {4'(i), 12'(pkt[i]), 16'(fidx[i])});
        end
      end
      out_ready = (($urandom % 4) != 0);
      left = 0;
      if (n >= 2000) begin
        for (int i = 0; i < NI; i++) left += expq[i].size() + int'(active[i]);
        left += int'(out_valid);
      end
    end
    chk("rand_drain_remaining", left, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
